// File: rtl/debug_halt_ctrl.sv
// rtl/debug_halt_ctrl.sv - debug responder: halt cause capture, host command handling, unhalt/halt_req drive
module debug_halt_ctrl #(
    parameter int COUNT_W        = 16,
    parameter int RESUME_TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               halted,
    input  logic [2:0]         halt_cause,
    input  logic               retire,
    output logic               unhalt,
    output logic               halt_req,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [3:0]         rsp_cause,
    output logic               rsp_err,
    output logic [COUNT_W-1:0] rsp_count,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_HALTED    = 2'b01,
        ST_RESUMING  = 2'b10,
        ST_STEPPING  = 2'b11
    } state_t;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_RESUME = 2'b01;
    localparam logic [1:0] OP_STEP   = 2'b10;
    localparam logic [1:0] OP_HALT   = 2'b11;

    localparam int TMO_W = $clog2(RESUME_TIMEOUT + 1);
    // Timeout fires on the RESUME_TIMEOUT-th RESUMING cycle that still sees halted.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RESUME_TIMEOUT - 1);

    state_t               state_q, state_d;
    logic                 unhalt_q, unhalt_d;
    logic                 halt_req_q, halt_req_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [3:0]           rsp_cause_q, rsp_cause_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [COUNT_W-1:0]   rsp_count_q, rsp_count_d;
    logic                 step_q, step_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;

    logic                 cmd_ready_c;
    logic                 cmd_fire;
    logic                 capture;

    assign cmd_ready_c = ((state_q == ST_RUN) && !halt_req_q) ||
                         ((state_q == ST_HALTED) && !rsp_valid_q);
    assign cmd_fire    = cmd_valid && cmd_ready_c;
    assign capture     = halted && ((state_q == ST_RUN) || (state_q == ST_STEPPING));

    always_comb begin
        state_d     = state_q;
        unhalt_d    = 1'b0;
        halt_req_d  = halt_req_q;
        rsp_valid_d = rsp_valid_q;
        rsp_cause_d = rsp_cause_q;
        rsp_err_d   = rsp_err_q;
        rsp_count_d = rsp_count_q;
        step_d      = step_q;
        tmo_d       = tmo_q;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            ST_RUN: begin
                // A HALT landing in the same cycle as a real halt is absorbed by the capture.
                if (!halted && cmd_fire && (cmd_op == OP_HALT)) begin
                    halt_req_d = 1'b1;
                end
            end
            ST_HALTED: begin
                if (cmd_fire && ((cmd_op == OP_RESUME) || (cmd_op == OP_STEP))) begin
                    unhalt_d = 1'b1;
                    state_d  = ST_RESUMING;
                    step_d   = (cmd_op == OP_STEP);
                    tmo_d    = '0;
                end
            end
            ST_RESUMING: begin
                if (!halted) begin
                    state_d = step_q ? ST_STEPPING : ST_RUN;
                end else if (tmo_q == TMO_LAST) begin
                    state_d     = ST_HALTED;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_STEPPING: begin
                if (!halted && retire && !halt_req_q) begin
                    halt_req_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (capture) begin
            rsp_cause_d = {halt_req_q, halt_cause};
            rsp_err_d   = 1'b0;
            rsp_valid_d = 1'b1;
            halt_req_d  = 1'b0;
            state_d     = ST_HALTED;
            if (!(&rsp_count_q)) begin
                rsp_count_d = rsp_count_q + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            unhalt_q    <= 1'b0;
            halt_req_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_cause_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_count_q <= '0;
            step_q      <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            unhalt_q    <= unhalt_d;
            halt_req_q  <= halt_req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_cause_q <= rsp_cause_d;
            rsp_err_q   <= rsp_err_d;
            rsp_count_q <= rsp_count_d;
            step_q      <= step_d;
            tmo_q       <= tmo_d;
        end
    end

    assign unhalt    = unhalt_q;
    assign halt_req  = halt_req_q;
    assign cmd_ready = cmd_ready_c;
    assign rsp_valid = rsp_valid_q;
    assign rsp_cause = rsp_cause_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_count = rsp_count_q;
    assign state     = state_q;

endmodule

// File: tb/tb_debug_halt_ctrl.sv
// tb/tb_debug_halt_ctrl.sv - vector-table bench for debug_halt_ctrl (COUNT_W=4 build)
module tb_debug_halt_ctrl;

    localparam int CW  = 4;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          halted;
    logic [2:0]    halt_cause;
    logic          retire;
    logic          unhalt;
    logic          halt_req;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [3:0]    rsp_cause;
    logic          rsp_err;
    logic [CW-1:0] rsp_count;
    logic [1:0]    state;

    debug_halt_ctrl #(.COUNT_W(CW), .RESUME_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .halted     (halted),
        .halt_cause (halt_cause),
        .retire     (retire),
        .unhalt     (unhalt),
        .halt_req   (halt_req),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_cause  (rsp_cause),
        .rsp_err    (rsp_err),
        .rsp_count  (rsp_count),
        .state      (state)
    );

    always #5 clk = ~clk;

    // expected = {state, unhalt, halt_req, cmd_ready, rsp_valid, rsp_cause, rsp_err, rsp_count}
    typedef struct {
        logic        h;
        logic [2:0]  hc;
        logic        rt;
        logic        cv;
        logic [1:0]  op;
        logic        rr;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [14:0] outs();
        return {state, unhalt, halt_req, cmd_ready, rsp_valid, rsp_cause, rsp_err, rsp_count};
    endfunction

    task automatic check_outs(input string name, input logic [14:0] exp);
        logic [14:0] act;
        act = outs();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%b exp=%b (st,uh,hr,cr,rv,cause,err,cnt)", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic push(input logic h, input logic [2:0] hc, input logic rt, input logic cv,
                        input logic [1:0] op, input logic rr,
                        input logic [1:0] st, input logic uh, input logic hr, input logic cr,
                        input logic rv, input logic [3:0] rc, input logic re, input logic [3:0] cnt);
        vec_t v;
        v.h = h; v.hc = hc; v.rt = rt; v.cv = cv; v.op = op; v.rr = rr;
        v.exp = {st, uh, hr, cr, rv, rc, re, cnt};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic h, input logic [2:0] hc, input logic rt, input logic cv,
                         input logic [1:0] op, input logic rr);
        halted = h; halt_cause = hc; retire = rt; cmd_valid = cv; cmd_op = op; rsp_ready = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        halted = 0; halt_cause = 0; retire = 0; cmd_valid = 0; cmd_op = 0; rsp_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        do_reset();
        check_outs("reset_state", {2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'd0});

        // halt capture, then held response with a refused RESUME and a changing cause input
        push(1,3'b100,0,0,0,0, 2'd1,0,0,0,1,4'b0100,0,4'd1);
        for (int i = 0; i < 5; i++)
            push(1,3'b011,0,1,1,0, 2'd1,0,0,0,1,4'b0100,0,4'd1);
        push(1,3'b000,0,0,0,1, 2'd1,0,0,1,0,4'b0100,0,4'd1);
        // RESUME, halted drops on the second RESUMING cycle
        push(1,3'b000,0,1,1,0, 2'd2,1,0,0,0,4'b0100,0,4'd1);
        push(1,3'b000,0,0,0,0, 2'd2,0,0,0,0,4'b0100,0,4'd1);
        push(0,3'b000,0,0,0,0, 2'd0,0,0,1,0,4'b0100,0,4'd1);
        // NOP, STEP, RESUME in RUN are no-ops
        push(0,3'b000,0,1,0,0, 2'd0,0,0,1,0,4'b0100,0,4'd1);
        push(0,3'b000,0,1,2,0, 2'd0,0,0,1,0,4'b0100,0,4'd1);
        push(0,3'b000,0,1,1,0, 2'd0,0,0,1,0,4'b0100,0,4'd1);
        // capture with zero cause, then STEP with two retires
        push(1,3'b000,0,0,0,0, 2'd1,0,0,0,1,4'b0000,0,4'd2);
        push(1,3'b000,0,0,0,1, 2'd1,0,0,1,0,4'b0000,0,4'd2);
        push(1,3'b000,0,1,2,0, 2'd2,1,0,0,0,4'b0000,0,4'd2);
        push(0,3'b000,0,0,0,0, 2'd3,0,0,0,0,4'b0000,0,4'd2);
        push(0,3'b000,1,0,0,0, 2'd3,0,1,0,0,4'b0000,0,4'd2);
        push(0,3'b000,1,1,3,0, 2'd3,0,1,0,0,4'b0000,0,4'd2);
        push(1,3'b000,0,0,0,0, 2'd1,0,0,0,1,4'b1000,0,4'd3);
        push(1,3'b000,0,0,0,1, 2'd1,0,0,1,0,4'b1000,0,4'd3);
        push(1,3'b000,0,1,1,0, 2'd2,1,0,0,0,4'b1000,0,4'd3);
        push(0,3'b000,0,0,0,0, 2'd0,0,0,1,0,4'b1000,0,4'd3);
        // HALT in RUN held for three cycles before the controller halts
        push(0,3'b000,0,1,3,0, 2'd0,0,1,0,0,4'b1000,0,4'd3);
        push(0,3'b000,0,1,3,0, 2'd0,0,1,0,0,4'b1000,0,4'd3);
        push(0,3'b000,1,0,0,0, 2'd0,0,1,0,0,4'b1000,0,4'd3);
        push(1,3'b000,0,0,0,0, 2'd1,0,0,0,1,4'b1000,0,4'd4);
        push(1,3'b000,0,0,0,1, 2'd1,0,0,1,0,4'b1000,0,4'd4);
        // RESUME with halted stuck high -> timeout after TMO RESUMING cycles
        push(1,3'b000,0,1,1,0, 2'd2,1,0,0,0,4'b1000,0,4'd4);
        for (int i = 0; i < TMO - 1; i++)
            push(1,3'b000,0,0,0,0, 2'd2,0,0,0,0,4'b1000,0,4'd4);
        push(1,3'b000,0,0,0,0, 2'd1,0,0,0,1,4'b1000,1,4'd4);
        push(1,3'b000,0,0,0,1, 2'd1,0,0,1,0,4'b1000,1,4'd4);
        // STEP ending in a trap before any retire
        push(1,3'b000,0,1,2,0, 2'd2,1,0,0,0,4'b1000,1,4'd4);
        push(0,3'b000,0,0,0,0, 2'd3,0,0,0,0,4'b1000,1,4'd4);
        push(1,3'b010,0,0,0,0, 2'd1,0,0,0,1,4'b0010,0,4'd5);
        push(1,3'b000,0,0,0,1, 2'd1,0,0,1,0,4'b0010,0,4'd5);
        push(1,3'b000,0,1,1,0, 2'd2,1,0,0,0,4'b0010,0,4'd5);
        push(0,3'b000,0,0,0,0, 2'd0,0,0,1,0,4'b0010,0,4'd5);
        // HALT accepted in the same cycle halted rises: debug bit stays 0
        push(1,3'b001,0,1,3,0, 2'd1,0,0,0,1,4'b0001,0,4'd6);

        foreach (vecs[i]) begin
            drive(vecs[i].h, vecs[i].hc, vecs[i].rt, vecs[i].cv, vecs[i].op, vecs[i].rr);
            check_outs($sformatf("vec%0d", i), vecs[i].exp);
        end

        // saturation: 2^CW+3 halt events from reset
        do_reset();
        for (int i = 1; i <= (1 << CW) + 3; i++) begin
            drive(1, 3'b100, 0, 0, 0, 0);
            check_val($sformatf("sat_count%0d", i), int'(rsp_count), (i < 15) ? i : 15);
            drive(1, 3'b000, 0, 0, 0, 1);
            drive(1, 3'b000, 0, 1, 1, 0);
            drive(0, 3'b000, 0, 0, 0, 0);
        end
        check_val("sat_final", int'(rsp_count), 15);

        // async reset in RESUMING
        drive(1, 3'b000, 0, 0, 0, 0);
        drive(1, 3'b000, 0, 0, 0, 1);
        drive(1, 3'b000, 0, 1, 1, 0);
        check_val("pre_reset_resuming", int'(state), 2);
        #2 reset_n = 1'b0;
        #1 check_outs("async_reset", {2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'd0});
        repeat (2) @(posedge clk);
        #1 check_val("no_unhalt_in_reset", int'(unhalt), 0);
        reset_n = 1'b1;
        drive(0, 3'b000, 0, 0, 0, 0);
        check_outs("after_reset", {2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
